// File: rtl/signal_freq_meter.sv
// Gated frequency/period meter: counts synchronized rising edges of sig_in over
// GATE_CYCLES reference cycles and reports the last edge-to-edge period.
`timescale 1ns/1ps
module signal_freq_meter #(
  parameter int unsigned GATE_CYCLES = 25000000,
  parameter int unsigned COUNT_W     = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               twentyFive_mhz_clk,
  input  logic               reset,
  input  logic               sig_in,
  input  logic               start,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ack,
  output logic [COUNT_W-1:0] freq_count,
  output logic [COUNT_W-1:0] period_count,
  output logic               no_signal,
  output logic               overflow
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q, sync_prev, sig_edge;

  logic [GATE_W-1:0]  gate_cnt;
  logic [COUNT_W-1:0] edge_cnt, period_cnt, last_period;
  logic               edges_seen, ovf;
  logic [COUNT_W-1:0] edge_cnt_nxt, period_cnt_nxt, last_period_nxt, period_inc;
  logic               ovf_nxt, gate_last;

  assign sync_q    = sync_ff[SYNC_STAGES-1];
  assign sig_edge  = sync_q & ~sync_prev;
  assign gate_last = (gate_cnt == GATE_W'(GATE_CYCLES - 1));

  always_ff @(posedge twentyFive_mhz_clk) begin
    if (reset) begin
      sync_ff   <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_ff   <= {sync_ff[SYNC_STAGES-2:0], sig_in};
      sync_prev <= sync_q;
    end
  end

  // Next values of the window counters for one MEASURE cycle; also used to
  // capture results on the final gate cycle so an edge there is included.
  always_comb begin
    edge_cnt_nxt    = edge_cnt;
    period_cnt_nxt  = period_cnt;
    last_period_nxt = last_period;
    ovf_nxt         = ovf;
    period_inc      = period_cnt;
    if (period_cnt == CNT_MAX) begin
      ovf_nxt = 1'b1;
    end else begin
      period_inc = period_cnt + 1'b1;
    end
    period_cnt_nxt = period_inc;
    if (sig_edge) begin
      if (edge_cnt == CNT_MAX) begin
        ovf_nxt = 1'b1;
      end else begin
        edge_cnt_nxt = edge_cnt + 1'b1;
      end
      if (edges_seen) begin
        last_period_nxt = period_inc;
      end
      period_cnt_nxt = '0;
    end
  end

  always_ff @(posedge twentyFive_mhz_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MEASURE;
      MEASURE: if (gate_last) state_nxt = DONE;
      DONE:    if (result_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    result_valid = (state == DONE);
  end

  always_ff @(posedge twentyFive_mhz_clk) begin
    if (reset) begin
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      period_cnt   <= '0;
      last_period  <= '0;
      edges_seen   <= 1'b0;
      ovf          <= 1'b0;
      freq_count   <= '0;
      period_count <= '0;
      no_signal    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            gate_cnt     <= '0;
            edge_cnt     <= '0;
            period_cnt   <= '0;
            last_period  <= '0;
            edges_seen   <= 1'b0;
            ovf          <= 1'b0;
            freq_count   <= '0;
            period_count <= '0;
            no_signal    <= 1'b0;
            overflow     <= 1'b0;
          end
        end
        MEASURE: begin
          gate_cnt    <= gate_cnt + 1'b1;
          edge_cnt    <= edge_cnt_nxt;
          period_cnt  <= period_cnt_nxt;
          last_period <= last_period_nxt;
          edges_seen  <= edges_seen | sig_edge;
          ovf         <= ovf_nxt;
          if (gate_last) begin
            freq_count   <= edge_cnt_nxt;
            period_count <= (edge_cnt_nxt >= COUNT_W'(2)) ? last_period_nxt : '0;
            no_signal    <= (edge_cnt_nxt < COUNT_W'(2));
            overflow     <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signal_freq_meter.sv
// Directed bench for signal_freq_meter: a 32-bit instance and a 4-bit instance,
// both with a 1000-cycle gate window.
`timescale 1ns/1ps
module tb_signal_freq_meter;

  logic clk = 1'b0;
  logic reset;
  logic sig_a, start_a, ack_a, busy_a, valid_a, nosig_a, ovf_a;
  logic [31:0] freq_a, period_a;
  logic sig_b, start_b, ack_b, busy_b, valid_b, nosig_b, ovf_b;
  logic [3:0] freq_b, period_b;

  int n_tests = 0;
  int n_fail  = 0;
  int tcur    = 0;

  always #20 clk = ~clk;

  signal_freq_meter #(.GATE_CYCLES(1000), .COUNT_W(32), .SYNC_STAGES(2)) dut_a (
    .twentyFive_mhz_clk(clk), .reset(reset), .sig_in(sig_a), .start(start_a),
    .busy(busy_a), .result_valid(valid_a), .result_ack(ack_a),
    .freq_count(freq_a), .period_count(period_a), .no_signal(nosig_a), .overflow(ovf_a)
  );

  signal_freq_meter #(.GATE_CYCLES(1000), .COUNT_W(4), .SYNC_STAGES(2)) dut_b (
    .twentyFive_mhz_clk(clk), .reset(reset), .sig_in(sig_b), .start(start_b),
    .busy(busy_b), .result_valid(valid_b), .result_ack(ack_b),
    .freq_count(freq_b), .period_count(period_b), .no_signal(nosig_b), .overflow(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    tcur++;
  endtask

  task automatic goto(input int n);
    while (tcur < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start is sampled on the next edge; that edge becomes cycle 0.
  task automatic begin_meas(input bit use_b);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    tcur = 0;
  endtask

  task automatic check_a(input string tag, input int f, input int p, input int ns, input int ov);
    chk({tag, "_valid"},  valid_a,  1);
    chk({tag, "_busy"},   busy_a,   1);
    chk({tag, "_freq"},   freq_a,   f);
    chk({tag, "_period"}, period_a, p);
    chk({tag, "_nosig"},  nosig_a,  ns);
    chk({tag, "_ovf"},    ovf_a,    ov);
  endtask

  task automatic check_b(input string tag, input int f, input int p, input int ns, input int ov);
    chk({tag, "_valid"},  valid_b,  1);
    chk({tag, "_freq"},   freq_b,   f);
    chk({tag, "_period"}, period_b, p);
    chk({tag, "_nosig"},  nosig_b,  ns);
    chk({tag, "_ovf"},    ovf_b,    ov);
  endtask

  task automatic ack_pulse_a();
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    chk("ack_a_valid_low", valid_a, 0);
  endtask

  // sig_in rises 3 cycles before each synchronized edge at gate 50,150,...,950
  task automatic square_run(input string tag);
    begin_meas(0);
    for (int k = 0; k < 10; k++) begin
      goto(47 + 100 * k);
      sig_a = 1'b1;
      goto(97 + 100 * k);
      sig_a = 1'b0;
    end
    goto(999);
    chk({tag, "_valid_early"}, valid_a, 0);
    chk({tag, "_busy_early"},  busy_a,  1);
    goto(1000);
    check_a(tag, 10, 100, 0, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sig_a = 1'b0; start_a = 1'b0; ack_a = 1'b0;
    sig_b = 1'b0; start_b = 1'b0; ack_b = 1'b0;
    repeat (3) tick();
    chk("rst_busy",   busy_a,   0);
    chk("rst_valid",  valid_a,  0);
    chk("rst_freq",   freq_a,   0);
    chk("rst_period", period_a, 0);
    chk("rst_nosig",  nosig_a,  0);
    chk("rst_ovf",    ovf_a,    0);
    chk("rst_b_busy", busy_b,   0);
    reset = 1'b0;
    tick();

    // Square wave, period 100
    square_run("t1");

    // Handshake: hold, start in DONE, start+ack together
    goto(1050);
    chk("hold_valid",  valid_a,  1);
    chk("hold_freq",   freq_a,   10);
    chk("hold_period", period_a, 100);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("done_start_valid", valid_a, 1);
    chk("done_start_freq",  freq_a,  10);
    start_a = 1'b1;
    ack_a   = 1'b1;
    tick();
    start_a = 1'b0;
    ack_a   = 1'b0;
    chk("ackstart_valid", valid_a, 0);
    chk("ackstart_busy",  busy_a,  0);
    chk("idle_keep_freq", freq_a,  10);
    chk("idle_keep_per",  period_a, 100);
    repeat (5) tick();
    chk("ackstart_no_new", busy_a, 0);

    // Signal held high across start; start pulsed in MEASURE
    sig_a = 1'b1;
    repeat (5) tick();
    begin_meas(0);
    chk("t2h_cleared_freq", freq_a, 0);
    chk("t2h_busy",         busy_a, 1);
    goto(500);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    goto(999);
    chk("t2h_valid_early", valid_a, 0);
    goto(1000);
    check_a("t2h", 0, 0, 1, 0);
    ack_pulse_a();

    // Signal held low
    sig_a = 1'b0;
    repeat (5) tick();
    begin_meas(0);
    goto(1000);
    check_a("t2l", 0, 0, 1, 0);
    ack_pulse_a();

    // Single pulse
    begin_meas(0);
    goto(97);  sig_a = 1'b1;
    goto(107); sig_a = 1'b0;
    goto(1000);
    check_a("t3", 1, 0, 1, 0);
    ack_pulse_a();

    // Edge on the final gate cycle counts
    begin_meas(0);
    goto(897); sig_a = 1'b1;
    goto(947); sig_a = 1'b0;
    goto(997); sig_a = 1'b1;
    goto(1000);
    check_a("t3_last", 2, 100, 0, 0);
    ack_pulse_a();
    sig_a = 1'b0;
    repeat (5) tick();

    // Edge one cycle after the window is not counted
    begin_meas(0);
    goto(497); sig_a = 1'b1;
    goto(547); sig_a = 1'b0;
    goto(998); sig_a = 1'b1;
    goto(1000);
    check_a("t3_after", 1, 0, 1, 0);
    ack_pulse_a();
    sig_a = 1'b0;
    repeat (5) tick();

    // 4-bit counters: 20 edges at period 10
    begin_meas(1);
    for (int k = 0; k < 20; k++) begin
      goto(10 + 10 * k);
      sig_b = 1'b1;
      goto(15 + 10 * k);
      sig_b = 1'b0;
    end
    goto(1000);
    check_b("t5_edges", 15, 10, 0, 1);
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;
    chk("t5_ack_valid", valid_b, 0);

    // 4-bit counters: two edges 20 cycles apart
    begin_meas(1);
    goto(10); sig_b = 1'b1;
    goto(15); sig_b = 1'b0;
    goto(30); sig_b = 1'b1;
    goto(35); sig_b = 1'b0;
    goto(1000);
    check_b("t5_gap", 2, 15, 0, 1);
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;

    // Reset mid-measurement, then a full measurement
    begin_meas(0);
    goto(480); sig_a = 1'b1;
    goto(500);
    reset = 1'b1;
    tick();
    chk("t6_busy",   busy_a,   0);
    chk("t6_valid",  valid_a,  0);
    chk("t6_freq",   freq_a,   0);
    chk("t6_period", period_a, 0);
    chk("t6_nosig",  nosig_a,  0);
    chk("t6_ovf",    ovf_a,    0);
    reset = 1'b0;
    sig_a = 1'b0;
    repeat (5) tick();
    chk("t6_stay_idle", busy_a, 0);
    square_run("t6_rerun");
    ack_pulse_a();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
